fb_write_arbiter: RTL and testbench

- Sits directly downstream of the ray-core array and upstream of the framebuffer memory write port.
- Each ray core outputs one shaded pixel per strobe. The block captures each pixel into a per-core FIFO, then arbitrates round-robin across cores.
- It converts (x, y, flip) into a linear framebuffer word address and issues one memory write at a time using a valid/ready handshake.
- It back-pressures the cores through per-core FIFO-full flags and keeps per-frame write statistics.

---
 rtl/fb_write_arbiter.sv | 232 +++++++++++++++++++++++
 tb/tb_fb_write_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter: collects shaded pixels from the ray cores into per-core
// FIFOs and drains them round-robin into the framebuffer write port. Each
// pixel becomes one word write at buffer_sel*W*H + y*W + x.
module fb_write_arbiter #(
  parameter int CORE_COUNT  = 4,
  parameter int FIFO_DEPTH  = 8,
  parameter int FB_WIDTH    = 160,
  parameter int FB_HEIGHT   = 120,
  parameter int ADDR_WIDTH  = 16,
  parameter int COLOR_WIDTH = 24
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic [CORE_COUNT-1:0]             strobe,
  input  logic [CORE_COUNT*10-1:0]          pixel_x,
  input  logic [CORE_COUNT*10-1:0]          pixel_y,
  input  logic [CORE_COUNT*COLOR_WIDTH-1:0] color,
  input  logic                              flip,
  input  logic                              frame_clear,
  input  logic                              mem_ready,
  output logic                              mem_w_valid,
  output logic [ADDR_WIDTH-1:0]             mem_w_addr,
  output logic [COLOR_WIDTH-1:0]            mem_w_data,
  output logic [CORE_COUNT-1:0]             fifo_full,
  output logic [31:0]                       pixels_written,
  output logic                              overflow,
  output logic                              range_error
);

  localparam int SEL_W = (CORE_COUNT > 1) ? $clog2(CORE_COUNT) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [SEL_W-1:0] LAST_C   = SEL_W'(CORE_COUNT - 1);
  localparam logic [31:0]      FB_W_U   = 32'(FB_WIDTH);
  localparam logic [31:0]      FB_H_U   = 32'(FB_HEIGHT);
  localparam logic [31:0]      FB_PIX_U = 32'(FB_WIDTH * FB_HEIGHT);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ISSUE = 1'b1;

  // One queued pixel; the target buffer is frozen at capture time.
  typedef struct packed {
    logic                   buf_sel;
    logic [9:0]             y;
    logic [9:0]             x;
    logic [COLOR_WIDTH-1:0] color;
  } entry_t;

  // FIFO storage and bookkeeping
  entry_t           r_mem     [CORE_COUNT][FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr  [CORE_COUNT];
  logic [PTR_W-1:0] r_rd_ptr  [CORE_COUNT];
  logic [CNT_W-1:0] r_count   [CORE_COUNT];
  logic [CORE_COUNT-1:0] r_full;

  // Issue side
  logic [0:0]             r_state;
  logic [SEL_W-1:0]       r_ptr;
  logic [SEL_W-1:0]       r_sel;
  logic                   r_valid;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [COLOR_WIDTH-1:0] r_data;
  logic [31:0]            r_pix_cnt;
  logic                   r_overflow;
  logic                   r_range_err;

  // Combinational helpers
  logic [CORE_COUNT-1:0] w_in_range;
  logic [CORE_COUNT-1:0] w_push;
  logic [CORE_COUNT-1:0] w_pop;
  logic [CORE_COUNT-1:0] w_drop_range;
  logic [CORE_COUNT-1:0] w_drop_full;
  logic [CORE_COUNT-1:0] w_nonempty;
  entry_t                w_new        [CORE_COUNT];
  logic [CNT_W-1:0]      w_count_next [CORE_COUNT];
  logic [SEL_W-1:0]      w_sel_next;
  logic [SEL_W-1:0]      w_start;
  logic [SEL_W-1:0]      w_pick;
  logic                  w_found;
  logic                  w_accept;
  logic                  w_load;
  entry_t                w_head;
  logic [ADDR_WIDTH-1:0] w_addr;

  // Per-core capture decision: range check, full check (on the registered
  // count, so a same-cycle pop never makes room), and next occupancy.
  always_comb begin
    // NOTE: every comb output gets a default before any conditional logic so no latch can be inferred.
    w_in_range   = '0;
    w_push       = '0;
    w_drop_range = '0;
    w_drop_full  = '0;
    w_nonempty   = '0;
    w_pop        = '0;
    for (int i = 0; i < CORE_COUNT; i++) begin
      w_in_range[i]   = (32'(pixel_x[10*i +: 10]) < FB_W_U) &&
                        (32'(pixel_y[10*i +: 10]) < FB_H_U);
      w_drop_range[i] = strobe[i] && !w_in_range[i];
      w_drop_full[i]  = strobe[i] && w_in_range[i] && (r_count[i] == DEPTH_C);
      w_push[i]       = strobe[i] && w_in_range[i] && (r_count[i] != DEPTH_C);
      w_nonempty[i]   = (r_count[i] != '0);
      w_pop[i]        = w_load && (w_pick == SEL_W'(i));
      w_new[i]        = '{buf_sel: flip,
                          y:       pixel_y[10*i +: 10],
                          x:       pixel_x[10*i +: 10],
                          color:   color[COLOR_WIDTH*i +: COLOR_WIDTH]};
      w_count_next[i] = r_count[i] + CNT_W'(w_push[i]) - CNT_W'(w_pop[i]);
    end
  end

  // Round-robin pick: in ISSUE the search starts just after the core being
  // retired so a back-to-back reload already honours the updated pointer.
  always_comb begin
    w_sel_next = (r_sel == LAST_C) ? '0 : r_sel + SEL_W'(1);
    w_start    = (r_state == S_ISSUE) ? w_sel_next : r_ptr;
    w_found    = 1'b0;
    w_pick     = '0;
    // Walk offsets from farthest to nearest so the nearest non-empty core wins.
    for (int k = CORE_COUNT - 1; k >= 0; k--) begin
      if (w_nonempty[(int'(w_start) + k) % CORE_COUNT]) begin
        w_found = 1'b1;
        w_pick  = SEL_W'((int'(w_start) + k) % CORE_COUNT);
      end
    end
  end

  assign w_accept = r_valid && mem_ready;
  assign w_load   = w_found && ((r_state == S_IDLE) || w_accept);
  assign w_head   = r_mem[w_pick][r_rd_ptr[w_pick]];
  assign w_addr   = ADDR_WIDTH'((w_head.buf_sel ? FB_PIX_U : 32'd0) +
                                32'(w_head.y) * FB_W_U + 32'(w_head.x));

  // FIFO storage write port.
  // NOTE: pixel storage is deliberately not reset; the counts and pointers gate every read, so stale words are never observed.
  always_ff @(posedge clk) begin
    for (int i = 0; i < CORE_COUNT; i++) begin
      if (w_push[i]) r_mem[i][r_wr_ptr[i]] <= w_new[i];
    end
  end

  // FIFO pointers, occupancy and registered full flags.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < CORE_COUNT; i++) begin
        r_wr_ptr[i] <= '0;
        r_rd_ptr[i] <= '0;
        r_count[i]  <= '0;
      end
      r_full <= '0;
    end else begin
      for (int i = 0; i < CORE_COUNT; i++) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (w_push[i]) r_wr_ptr[i] <= r_wr_ptr[i] + PTR_W'(1);
        if (w_pop[i])  r_rd_ptr[i] <= r_rd_ptr[i] + PTR_W'(1);
        r_count[i] <= w_count_next[i];
        r_full[i]  <= (w_count_next[i] == DEPTH_C);
      end
    end
  end

  // Issue FSM: load a write from IDLE, hold it in ISSUE until accepted,
  // then reload back-to-back or fall back to IDLE.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_sel   <= '0;
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_sel   <= w_pick;
            r_addr  <= w_addr;
            r_data  <= w_head.color;
            r_valid <= 1'b1;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (w_accept) begin
            r_ptr <= w_sel_next;
            if (w_found) begin
              r_sel  <= w_pick;
              r_addr <= w_addr;
              r_data <= w_head.color;
            end else begin
              r_valid <= 1'b0;
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Frame statistics; a drop in the clearing cycle still sets its sticky flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pix_cnt   <= '0;
      r_overflow  <= 1'b0;
      r_range_err <= 1'b0;
    end else begin
      if (frame_clear) begin
        r_pix_cnt   <= {31'd0, w_accept};
        r_overflow  <= |w_drop_full;
        r_range_err <= |w_drop_range;
      end else begin
        if (w_accept) r_pix_cnt <= r_pix_cnt + 32'd1;
        if (|w_drop_full)  r_overflow  <= 1'b1;
        if (|w_drop_range) r_range_err <= 1'b1;
      end
    end
  end

  assign mem_w_valid    = r_valid;
  assign mem_w_addr     = r_addr;
  assign mem_w_data     = r_data;
  assign fifo_full      = r_full;
  assign pixels_written = r_pix_cnt;
  assign overflow       = r_overflow;
  assign range_error    = r_range_err;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter: inputs change and outputs are
// sampled 1 ns after the rising edge; expected values are hand-computed.
module tb_fb_write_arbiter;

  logic        clk;
  logic        resetn;
  logic [3:0]  strobe;
  logic [39:0] pixel_x;
  logic [39:0] pixel_y;
  logic [95:0] color;
  logic        flip;
  logic        frame_clear;
  logic        mem_ready;
  logic        mem_w_valid;
  logic [15:0] mem_w_addr;
  logic [23:0] mem_w_data;
  logic [3:0]  fifo_full;
  logic [31:0] pixels_written;
  logic        overflow;
  logic        range_error;

  int checks = 0;
  int errors = 0;

  fb_write_arbiter dut (
    .clk            (clk),
    .resetn         (resetn),
    .strobe         (strobe),
    .pixel_x        (pixel_x),
    .pixel_y        (pixel_y),
    .color          (color),
    .flip           (flip),
    .frame_clear    (frame_clear),
    .mem_ready      (mem_ready),
    .mem_w_valid    (mem_w_valid),
    .mem_w_addr     (mem_w_addr),
    .mem_w_data     (mem_w_data),
    .fifo_full      (fifo_full),
    .pixels_written (pixels_written),
    .overflow       (overflow),
    .range_error    (range_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pix(input int core, input int x, input int y, input logic [23:0] c);
    pixel_x[core*10 +: 10] = 10'(x);
    pixel_y[core*10 +: 10] = 10'(y);
    color[core*24 +: 24]   = c;
  endtask

  task automatic test_reset();
    resetn = 1'b0; strobe = '0; pixel_x = '0; pixel_y = '0; color = '0;
    flip = 1'b0; frame_clear = 1'b0; mem_ready = 1'b0;
    tick(); tick();
    checks++; if (mem_w_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", mem_w_valid); end
    checks++; if (mem_w_addr !== 16'd0) begin errors++; $display("FAIL reset_addr got %0d exp 0", mem_w_addr); end
    checks++; if (mem_w_data !== 24'd0) begin errors++; $display("FAIL reset_data got %h exp 0", mem_w_data); end
    checks++; if (fifo_full !== 4'd0) begin errors++; $display("FAIL reset_full got %b exp 0000", fifo_full); end
    checks++; if (pixels_written !== 32'd0) begin errors++; $display("FAIL reset_pw got %0d exp 0", pixels_written); end
    checks++; if ({overflow, range_error} !== 2'b00) begin errors++; $display("FAIL reset_sticky got %b exp 00", {overflow, range_error}); end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_single();
    mem_ready = 1'b1; flip = 1'b0;
    set_pix(0, 3, 2, 24'h112233);
    strobe = 4'b0001;
    tick();                       // cycle N+1
    strobe = '0;
    checks++; if (mem_w_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got %0b exp 0", mem_w_valid); end
    tick();                       // cycle N+2
    checks++; if (mem_w_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %0b exp 1", mem_w_valid); end
    checks++; if (mem_w_addr !== 16'd323) begin errors++; $display("FAIL single_addr got %0d exp 323", mem_w_addr); end
    checks++; if (mem_w_data !== 24'h112233) begin errors++; $display("FAIL single_data got %h exp 112233", mem_w_data); end
    tick();
    checks++; if (mem_w_valid !== 1'b0) begin errors++; $display("FAIL single_drop_valid got %0b exp 0", mem_w_valid); end
    checks++; if (pixels_written !== 32'd1) begin errors++; $display("FAIL single_pw got %0d exp 1", pixels_written); end
  endtask

  task automatic test_flip();
    flip = 1'b1;
    set_pix(2, 159, 119, 24'hABCDEF);
    strobe = 4'b0100;
    tick();
    strobe = '0;
    flip = 1'b0;                  // must not affect the already captured pixel
    tick();
    checks++; if (mem_w_valid !== 1'b1) begin errors++; $display("FAIL flip_valid got %0b exp 1", mem_w_valid); end
    checks++; if (mem_w_addr !== 16'd38399) begin errors++; $display("FAIL flip_addr got %0d exp 38399", mem_w_addr); end
    checks++; if (mem_w_data !== 24'hABCDEF) begin errors++; $display("FAIL flip_data got %h exp abcdef", mem_w_data); end
    tick();
    checks++; if (pixels_written !== 32'd2) begin errors++; $display("FAIL flip_pw got %0d exp 2", pixels_written); end
  endtask

  task automatic test_round_robin();
    // Restart so the round-robin pointer is back at core 0.
    resetn = 1'b0; tick(); resetn = 1'b1; tick();
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_pix(i, 10 + i, i, 24'(i + 1) * 24'h010101);
    strobe = 4'b1111;
    tick();
    strobe = '0;
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++; if (mem_w_valid !== 1'b1) begin errors++; $display("FAIL rr_valid_%0d got %0b exp 1", i, mem_w_valid); end
      checks++; if (mem_w_addr !== 16'(i * 160 + 10 + i)) begin errors++; $display("FAIL rr_addr_%0d got %0d exp %0d", i, mem_w_addr, i * 161 + 10); end
      checks++; if (mem_w_data !== 24'(i + 1) * 24'h010101) begin errors++; $display("FAIL rr_data_%0d got %h exp %h", i, mem_w_data, 24'(i + 1) * 24'h010101); end
      tick();
    end
    checks++; if (mem_w_valid !== 1'b0) begin errors++; $display("FAIL rr_end_valid got %0b exp 0", mem_w_valid); end
    checks++; if (pixels_written !== 32'd4) begin errors++; $display("FAIL rr_pw got %0d exp 4", pixels_written); end
  endtask

  task automatic test_back_pressure();
    mem_ready = 1'b0;
    // Park a core-0 write in the issue register (addr 100*160 = 16000).
    set_pix(0, 0, 100, 24'h0000AA);
    strobe = 4'b0001;
    tick();
    strobe = '0;
    tick();
    checks++; if (mem_w_valid !== 1'b1 || mem_w_addr !== 16'd16000) begin errors++; $display("FAIL bp_park got v=%0b a=%0d exp v=1 a=16000", mem_w_valid, mem_w_addr); end
    // Nine strobes on core 1 while stalled: 8 fit, the 9th overflows.
    for (int k = 1; k <= 9; k++) begin
      set_pix(1, 19 + k, 50, 24'h0000FF + 24'(k));
      strobe = 4'b0010;
      tick();
      if (k == 5) begin
        checks++; if (mem_w_addr !== 16'd16000 || mem_w_data !== 24'h0000AA) begin errors++; $display("FAIL bp_stable got a=%0d d=%h exp a=16000 d=0000aa", mem_w_addr, mem_w_data); end
      end
      if (k == 7) begin
        checks++; if (fifo_full[1] !== 1'b0) begin errors++; $display("FAIL bp_full7 got %0b exp 0", fifo_full[1]); end
      end
      if (k == 8) begin
        checks++; if (fifo_full[1] !== 1'b1) begin errors++; $display("FAIL bp_full8 got %0b exp 1", fifo_full[1]); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL bp_ovf8 got %0b exp 0", overflow); end
      end
      if (k == 9) begin
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL bp_ovf9 got %0b exp 1", overflow); end
      end
    end
    strobe = '0;
    checks++; if (mem_w_valid !== 1'b1 || mem_w_addr !== 16'd16000) begin errors++; $display("FAIL bp_hold got v=%0b a=%0d exp v=1 a=16000", mem_w_valid, mem_w_addr); end
    mem_ready = 1'b1;
    tick();                       // core-0 write retired, first core-1 entry loaded
    for (int k = 0; k < 8; k++) begin
      checks++; if (mem_w_valid !== 1'b1) begin errors++; $display("FAIL bp_drain_valid_%0d got %0b exp 1", k, mem_w_valid); end
      checks++; if (mem_w_addr !== 16'(8000 + 20 + k)) begin errors++; $display("FAIL bp_drain_addr_%0d got %0d exp %0d", k, mem_w_addr, 8020 + k); end
      checks++; if (mem_w_data !== 24'h000100 + 24'(k)) begin errors++; $display("FAIL bp_drain_data_%0d got %h exp %h", k, mem_w_data, 24'h000100 + 24'(k)); end
      tick();
    end
    checks++; if (mem_w_valid !== 1'b0) begin errors++; $display("FAIL bp_end_valid got %0b exp 0", mem_w_valid); end
    checks++; if (pixels_written !== 32'd13) begin errors++; $display("FAIL bp_pw got %0d exp 13", pixels_written); end
    checks++; if (fifo_full !== 4'b0000) begin errors++; $display("FAIL bp_full_end got %b exp 0000", fifo_full); end
  endtask

  task automatic test_range();
    mem_ready = 1'b1;
    set_pix(3, 160, 0, 24'hFFFFFF);
    strobe = 4'b1000;
    tick();
    strobe = '0;
    checks++; if (range_error !== 1'b1) begin errors++; $display("FAIL range_x_flag got %0b exp 1", range_error); end
    tick(); tick();
    checks++; if (mem_w_valid !== 1'b0) begin errors++; $display("FAIL range_x_nowrite got %0b exp 0", mem_w_valid); end
    checks++; if (pixels_written !== 32'd13) begin errors++; $display("FAIL range_x_pw got %0d exp 13", pixels_written); end
    frame_clear = 1'b1;
    tick();
    frame_clear = 1'b0;
    checks++; if (range_error !== 1'b0) begin errors++; $display("FAIL clear_range got %0b exp 0", range_error); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL clear_ovf got %0b exp 0", overflow); end
    checks++; if (pixels_written !== 32'd0) begin errors++; $display("FAIL clear_pw got %0d exp 0", pixels_written); end
    set_pix(3, 0, 120, 24'h777777);
    strobe = 4'b1000;
    tick();
    strobe = '0;
    checks++; if (range_error !== 1'b1) begin errors++; $display("FAIL range_y_flag got %0b exp 1", range_error); end
    tick(); tick();
    checks++; if (mem_w_valid !== 1'b0) begin errors++; $display("FAIL range_y_nowrite got %0b exp 0", mem_w_valid); end
  endtask

  task automatic test_clear_with_accept();
    mem_ready = 1'b1;
    set_pix(1, 1, 1, 24'h123456);
    strobe = 4'b0010;
    tick();
    strobe = '0;
    tick();
    checks++; if (mem_w_valid !== 1'b1 || mem_w_addr !== 16'd161) begin errors++; $display("FAIL cwa_write got v=%0b a=%0d exp v=1 a=161", mem_w_valid, mem_w_addr); end
    frame_clear = 1'b1;           // same cycle as the acceptance
    tick();
    frame_clear = 1'b0;
    checks++; if (pixels_written !== 32'd1) begin errors++; $display("FAIL cwa_pw got %0d exp 1", pixels_written); end
    checks++; if (range_error !== 1'b0) begin errors++; $display("FAIL cwa_range got %0b exp 0", range_error); end
  endtask

  task automatic test_reset_mid_issue();
    int valid_seen;
    mem_ready = 1'b0;
    set_pix(2, 5, 5, 24'h555555);
    strobe = 4'b0100;
    tick();
    strobe = '0;
    tick();
    checks++; if (mem_w_valid !== 1'b1) begin errors++; $display("FAIL rmi_valid got %0b exp 1", mem_w_valid); end
    for (int k = 0; k < 8; k++) begin
      set_pix(0, k, 7, 24'(k));
      strobe = 4'b0001;
      tick();
    end
    strobe = '0;
    checks++; if (fifo_full !== 4'b0001) begin errors++; $display("FAIL rmi_full_pre got %b exp 0001", fifo_full); end
    #2 resetn = 1'b0;
    #1;
    checks++; if (mem_w_valid !== 1'b0) begin errors++; $display("FAIL rmi_valid_rst got %0b exp 0", mem_w_valid); end
    checks++; if (fifo_full !== 4'b0000) begin errors++; $display("FAIL rmi_full_rst got %b exp 0000", fifo_full); end
    checks++; if (mem_w_addr !== 16'd0) begin errors++; $display("FAIL rmi_addr_rst got %0d exp 0", mem_w_addr); end
    #2 resetn = 1'b1;
    mem_ready = 1'b1;
    valid_seen = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (mem_w_valid === 1'b1) valid_seen++;
    end
    checks++; if (valid_seen != 0) begin errors++; $display("FAIL rmi_replay got %0d writes exp 0", valid_seen); end
    checks++; if (pixels_written !== 32'd0) begin errors++; $display("FAIL rmi_pw got %0d exp 0", pixels_written); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_flip();
    test_round_robin();
    test_back_pressure();
    test_range();
    test_clear_with_accept();
    test_reset_mid_issue();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net against a hung run.
  initial begin
    #200000;
    $display("FAIL timeout got no completion exp completion within 200000 ns");
    $fatal(1, "timeout");
  end

endmodule
